fpu_req_issuer: RTL and testbench
=================================

Name: fpu_req_issuer

Overview:
- Initiator-side companion to the FPU wrapper.
- Accepts FPU operations from the issue pipeline, allocates a small in-flight tag per operation, and stores per-op metadata (warp id, rd, PC and similar) in a tag table.
- Drives the FPU valid/ready request interface with that tag; on each FPU response, looks up the metadata, frees the tag and presents a registered commit response.
- Accumulates sticky fflags.

Parameters:
- NUM_LANES, 1, lanes per request.
- XLEN, 32, data width per lane.
- NUM_TAGS, 8, in-flight capacity; power of two, ≥2. TAGW = log2(NUM_TAGS).
- META_WIDTH, 16, opaque metadata bits stored per tag.

Ports:
- clk  in  1  clock.
- reset_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request valid.
- req_ready  out  1  pipeline request accepted.
- req_meta  in  META_WIDTH  metadata to return with the result.
- req_op  in  4  FPU op type.
- req_fmt  in  2  format.
- req_frm  in  3  rounding mode.
- req_dataa/req_datab/req_datac  in  NUM_LANES*XLEN  operands.
- fpu_valid_in  out  1  request valid to FPU.
- fpu_ready_in  in  1  FPU accepts request.
- fpu_op_type/fpu_fmt/fpu_frm  out  4/2/3  forwarded op fields.
- fpu_dataa/fpu_datab/fpu_datac  out  NUM_LANES*XLEN  forwarded operands.
- fpu_tag_in  out  TAGW  allocated tag.
- fpu_valid_out  in  1  FPU response valid.
- fpu_ready_out  out  1  response accepted.
- fpu_result  in  NUM_LANES*XLEN  result.
- fpu_has_fflags  in  1  response carries flags.
- fpu_fflags  in  5  {NV,DZ,OF,UF,NX}.
- fpu_tag_out  in  TAGW  response tag.
- rsp_valid  out  1  commit valid.
- rsp_ready  in  1  commit accepted.
- rsp_meta  out  META_WIDTH  metadata of the completed op.
- rsp_result  out  NUM_LANES*XLEN  result.
- rsp_fflags  out  5  flags of this op (0 if !has_fflags).
- fflags_acc  out  5  sticky OR of all flags.
- fflags_clr  in  1  clear sticky flags.
- pending  out  TAGW+1  in-flight count.
- tag_err  out  1  sticky: response arrived with a free tag.

Behaviour:
- Reset (async assert, sync deassert handled upstream):
  - All tags free.
  - pending=0, rsp_valid=0, rsp_meta/rsp_result/rsp_fflags=0, fflags_acc=0, tag_err=0.
  - Metadata table is not reset.
- Request path (combinational pass-through, no added latency):
  - fpu_valid_in = req_valid & has_free.
  - req_ready = fpu_ready_in & has_free.
  - All fpu_* request fields equal the req_* fields.
  - fpu_tag_in = lowest-index free tag.
  - No dependency of fpu_valid_in on fpu_ready_in.
- Allocation on req fire (req_valid & req_ready): table[tag] <= req_meta; in-use bit set at the clock edge.
- Full (pending==NUM_TAGS): has_free=0, fpu_valid_in=0, req_ready=0.
- Response path: one-entry output register.
  - fpu_ready_out = !rsp_valid | rsp_ready.
  - On response fire: rsp_meta <= table[fpu_tag_out], rsp_result <= fpu_result, rsp_fflags <= has_fflags ? fpu_fflags : 0, rsp_valid <= 1, in-use[fpu_tag_out] cleared.
  - Latency: FPU response to rsp_valid is 1 cycle.
  - Full throughput of one response per cycle while rsp_ready=1.
  - rsp_valid drops after rsp_ready with no new response.
- A tag freed in cycle N is allocatable from cycle N+1, never in the same cycle.
- Simultaneous alloc and free in one cycle: pending unchanged; the two tags are distinct.
- Free-tag response (in-use bit already 0):
  - Still forwarded.
  - tag_err <= 1, sticky until reset.
  - pending is not decremented; no underflow.
- fflags_acc:
  - On response fire with has_fflags, acc <= acc | fpu_fflags.
  - fflags_clr has priority over the old value: clr plus a same-cycle response gives acc <= new flags only.
- Output-held stability: while rsp_valid & !rsp_ready, all rsp_* fields are held stable.
- Reset mid-operation: all in-flight state is discarded. Any FPU response arriving after reset sets tag_err.

Optional Feature:
- Macro FPU_REQ_ISSUER_PERF_EN.
- When defined, adds outputs perf_stall_cycles[31:0] and perf_ops_done[31:0].
  - perf_stall_cycles increments each cycle with req_valid & !has_free.
  - perf_ops_done increments on each response fire.
  - Both wrap at 2^32 and reset to 0.
- When undefined, these ports and counters do not exist.

Test Plan:
- Single op: req meta=0x00A5, FPU responds 3 cycles later with tag 0, result 0x3F800000, flags 0x01 → fpu_tag_in=0; rsp_valid one cycle after the response with meta 0x00A5 and result 0x3F800000; fflags_acc=0x01; pending 1→0.
- Fill: 8 back-to-back requests with no responses → tags 0..7 issued; pending=8; 9th request sees req_ready=0 and fpu_valid_in=0. Respond tag 3 → next request gets tag 3 in the following cycle, not the same cycle.
- Out-of-order return: issue tags 0,1,2 (meta 0x10,0x11,0x12); respond 2,0,1 → rsp_meta sequence 0x12,0x10,0x11.
- Backpressure: rsp_ready=0 with a response pending → fpu_ready_out=0; rsp fields held for 5 cycles; rsp_ready=1 drains with no loss or duplication.
- fflags: response flags 0x04 while fflags_clr=1 with acc=0x11 → acc=0x04. Response with has_fflags=0 and fflags=0x1F → acc unchanged, rsp_fflags=0.
- Error and reset: response with unallocated tag 5 → tag_err=1 and pending unchanged. Assert reset_n=0 with 4 ops pending → pending=0, rsp_valid=0, tag_err=0 immediately.

Source files
------------

// File: rtl/fpu_req_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : fpu_req_issuer
//  Brief    : Initiator-side FPU request issuer. Allocates in-flight tags,
//             stores per-op metadata, forwards requests to the FPU, and turns
//             tagged FPU responses into a registered commit response with
//             sticky fflags accumulation and tag-error detection.
//  Options  : FPU_REQ_ISSUER_PERF_EN adds perf_stall_cycles / perf_ops_done.
//  Revision : 1.0 - initial release
// ============================================================================
module fpu_req_issuer #(
  parameter int NUM_LANES  = 1,
  parameter int XLEN       = 32,
  parameter int NUM_TAGS   = 8,
  parameter int META_WIDTH = 16
) (
  input  logic                            clk,
  input  logic                            reset_n,
  // Pipeline request side
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [META_WIDTH-1:0]           req_meta,
  input  logic [3:0]                      req_op,
  input  logic [1:0]                      req_fmt,
  input  logic [2:0]                      req_frm,
  input  logic [NUM_LANES*XLEN-1:0]       req_dataa,
  input  logic [NUM_LANES*XLEN-1:0]       req_datab,
  input  logic [NUM_LANES*XLEN-1:0]       req_datac,
  // FPU request side
  output logic                            fpu_valid_in,
  input  logic                            fpu_ready_in,
  output logic [3:0]                      fpu_op_type,
  output logic [1:0]                      fpu_fmt,
  output logic [2:0]                      fpu_frm,
  output logic [NUM_LANES*XLEN-1:0]       fpu_dataa,
  output logic [NUM_LANES*XLEN-1:0]       fpu_datab,
  output logic [NUM_LANES*XLEN-1:0]       fpu_datac,
  output logic [$clog2(NUM_TAGS)-1:0]     fpu_tag_in,
  // FPU response side
  input  logic                            fpu_valid_out,
  output logic                            fpu_ready_out,
  input  logic [NUM_LANES*XLEN-1:0]       fpu_result,
  input  logic                            fpu_has_fflags,
  input  logic [4:0]                      fpu_fflags,
  input  logic [$clog2(NUM_TAGS)-1:0]     fpu_tag_out,
  // Commit response side
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [META_WIDTH-1:0]           rsp_meta,
  output logic [NUM_LANES*XLEN-1:0]       rsp_result,
  output logic [4:0]                      rsp_fflags,
  // Status
  output logic [4:0]                      fflags_acc,
  input  logic                            fflags_clr,
  output logic [$clog2(NUM_TAGS):0]       pending,
`ifdef FPU_REQ_ISSUER_PERF_EN
  output logic [31:0]                     perf_stall_cycles,
  output logic [31:0]                     perf_ops_done,
`endif
  output logic                            tag_err
);

  localparam int TAGW = $clog2(NUM_TAGS);
  localparam int DW   = NUM_LANES * XLEN;

  logic [NUM_TAGS-1:0]   r_inuse;
  logic [META_WIDTH-1:0] r_meta_tbl [NUM_TAGS];
  logic [TAGW:0]         r_pending;
  logic                  r_rsp_valid;
  logic [META_WIDTH-1:0] r_rsp_meta;
  logic [DW-1:0]         r_rsp_result;
  logic [4:0]            r_rsp_fflags;
  logic [4:0]            r_fflags_acc;
  logic                  r_tag_err;

  logic                  w_has_free;
  logic [TAGW-1:0]       w_free_tag;
  logic                  w_req_fire;
  logic                  w_rsp_fire;
  logic                  w_free_busy;
  logic [NUM_TAGS-1:0]   w_inuse_nxt;
  logic [TAGW:0]         w_pending_nxt;
  logic [4:0]            w_new_flags;

  // Free-tag availability is derived from the in-use vector, so a tag freed
  // this cycle only becomes visible after the clock edge.
  assign w_has_free  = ~(&r_inuse);
  assign w_req_fire  = req_valid & req_ready;
  assign w_rsp_fire  = fpu_valid_out & fpu_ready_out;
  assign w_free_busy = w_rsp_fire & r_inuse[fpu_tag_out];
  assign w_new_flags = fpu_has_fflags ? fpu_fflags : 5'd0;

  // Request pass-through
  assign fpu_valid_in  = req_valid & w_has_free;
  assign req_ready     = fpu_ready_in & w_has_free;
  assign fpu_op_type   = req_op;
  assign fpu_fmt       = req_fmt;
  assign fpu_frm       = req_frm;
  assign fpu_dataa     = req_dataa;
  assign fpu_datab     = req_datab;
  assign fpu_datac     = req_datac;
  assign fpu_tag_in    = w_free_tag;
  assign fpu_ready_out = ~r_rsp_valid | rsp_ready;

  assign rsp_valid  = r_rsp_valid;
  assign rsp_meta   = r_rsp_meta;
  assign rsp_result = r_rsp_result;
  assign rsp_fflags = r_rsp_fflags;
  assign fflags_acc = r_fflags_acc;
  assign pending    = r_pending;
  assign tag_err    = r_tag_err;

  // Lowest-index free tag: scan downward so the smallest index wins
  always_comb begin
    w_free_tag = '0;
    for (int i = NUM_TAGS - 1; i >= 0; i--) begin
      if (!r_inuse[i]) w_free_tag = TAGW'(i);
    end
  end

  // Next in-use vector: clear on response, then set on allocation
  always_comb begin
    w_inuse_nxt = r_inuse;
    if (w_rsp_fire) w_inuse_nxt[fpu_tag_out] = 1'b0;
    if (w_req_fire) w_inuse_nxt[w_free_tag]  = 1'b1;
  end

  // Next pending count; a response on a free tag never decrements
  always_comb begin
    case ({w_req_fire, w_free_busy})
      2'b10:   w_pending_nxt = r_pending + 1'b1;
      2'b01:   w_pending_nxt = r_pending - 1'b1;
      default: w_pending_nxt = r_pending;
    endcase
  end

  // Metadata table: written on allocation, intentionally not reset
  always_ff @(posedge clk) begin
    if (w_req_fire) r_meta_tbl[w_free_tag] <= req_meta;
  end

  // Tag bookkeeping and error flag
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_inuse   <= '0;
      r_pending <= '0;
      r_tag_err <= 1'b0;
    end else begin
      r_inuse   <= w_inuse_nxt;
      r_pending <= w_pending_nxt;
      if (w_rsp_fire && !r_inuse[fpu_tag_out]) r_tag_err <= 1'b1;
    end
  end

  // One-entry commit response register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_meta   <= '0;
      r_rsp_result <= '0;
      r_rsp_fflags <= '0;
    end else if (w_rsp_fire) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_meta   <= r_meta_tbl[fpu_tag_out];
      r_rsp_result <= fpu_result;
      r_rsp_fflags <= w_new_flags;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end

  // Sticky fflags; clear discards the old value but keeps same-cycle flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_fflags_acc <= '0;
    end else if (fflags_clr) begin
      r_fflags_acc <= w_rsp_fire ? w_new_flags : 5'd0;
    end else if (w_rsp_fire) begin
      r_fflags_acc <= r_fflags_acc | w_new_flags;
    end
  end

`ifdef FPU_REQ_ISSUER_PERF_EN
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_done;

  assign perf_stall_cycles = r_perf_stall;
  assign perf_ops_done     = r_perf_done;

  // Free-running wrap-around performance counters
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_perf_stall <= '0;
      r_perf_done  <= '0;
    end else begin
      if (req_valid && !w_has_free) r_perf_stall <= r_perf_stall + 32'd1;
      if (w_rsp_fire)               r_perf_done  <= r_perf_done + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpu_req_issuer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fpu_req_issuer
//  Brief    : Directed self-checking testbench for fpu_req_issuer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fpu_req_issuer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid, req_ready;
  logic [15:0] req_meta;
  logic [3:0]  req_op;
  logic [1:0]  req_fmt;
  logic [2:0]  req_frm;
  logic [31:0] req_dataa, req_datab, req_datac;
  logic        fpu_valid_in, fpu_ready_in;
  logic [3:0]  fpu_op_type;
  logic [1:0]  fpu_fmt;
  logic [2:0]  fpu_frm;
  logic [31:0] fpu_dataa, fpu_datab, fpu_datac;
  logic [2:0]  fpu_tag_in;
  logic        fpu_valid_out, fpu_ready_out;
  logic [31:0] fpu_result;
  logic        fpu_has_fflags;
  logic [4:0]  fpu_fflags;
  logic [2:0]  fpu_tag_out;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_meta;
  logic [31:0] rsp_result;
  logic [4:0]  rsp_fflags, fflags_acc;
  logic        fflags_clr;
  logic [3:0]  pending;
  logic        tag_err;

  int errors = 0;
  int checks = 0;

  fpu_req_issuer dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_meta(req_meta),
    .req_op(req_op), .req_fmt(req_fmt), .req_frm(req_frm),
    .req_dataa(req_dataa), .req_datab(req_datab), .req_datac(req_datac),
    .fpu_valid_in(fpu_valid_in), .fpu_ready_in(fpu_ready_in),
    .fpu_op_type(fpu_op_type), .fpu_fmt(fpu_fmt), .fpu_frm(fpu_frm),
    .fpu_dataa(fpu_dataa), .fpu_datab(fpu_datab), .fpu_datac(fpu_datac),
    .fpu_tag_in(fpu_tag_in),
    .fpu_valid_out(fpu_valid_out), .fpu_ready_out(fpu_ready_out),
    .fpu_result(fpu_result), .fpu_has_fflags(fpu_has_fflags),
    .fpu_fflags(fpu_fflags), .fpu_tag_out(fpu_tag_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_meta(rsp_meta),
    .rsp_result(rsp_result), .rsp_fflags(rsp_fflags),
    .fflags_acc(fflags_acc), .fflags_clr(fflags_clr),
    .pending(pending), .tag_err(tag_err)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one request for one cycle (fires at the next edge if ready)
  task automatic issue(input logic [15:0] meta);
    req_valid = 1'b1;
    req_meta  = meta;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic rsp_start(input logic [2:0] tag, input logic [31:0] res,
                           input logic has, input logic [4:0] flags);
    fpu_valid_out  = 1'b1;
    fpu_tag_out    = tag;
    fpu_result     = res;
    fpu_has_fflags = has;
    fpu_fflags     = flags;
  endtask

  task automatic rsp_stop();
    fpu_valid_out  = 1'b0;
    fpu_has_fflags = 1'b0;
    fpu_fflags     = 5'd0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #3;
    checks++; if (pending !== 4'd0) begin errors++; $display("FAIL reset_pending: got %0d expected 0", pending); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 0", rsp_valid); end
    checks++; if (rsp_meta !== 16'h0 || rsp_result !== 32'h0 || rsp_fflags !== 5'h0) begin errors++; $display("FAIL reset_rsp_fields: got %h/%h/%h expected 0/0/0", rsp_meta, rsp_result, rsp_fflags); end
    checks++; if (fflags_acc !== 5'h0 || tag_err !== 1'b0) begin errors++; $display("FAIL reset_acc_err: got %h/%b expected 0/0", fflags_acc, tag_err); end
    checks++; if (req_ready !== 1'b1 || fpu_tag_in !== 3'd0) begin errors++; $display("FAIL reset_ready_tag: got %b/%0d expected 1/0", req_ready, fpu_tag_in); end
    tick();
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_single_op();
    req_valid = 1'b1; req_meta = 16'h00A5; req_op = 4'h7; req_fmt = 2'd1;
    req_frm = 3'd3; req_dataa = 32'h11111111; req_datab = 32'h22222222;
    req_datac = 32'h33333333;
    #1;
    checks++; if (fpu_valid_in !== 1'b1 || fpu_tag_in !== 3'd0) begin errors++; $display("FAIL single_issue: got valid=%b tag=%0d expected 1/0", fpu_valid_in, fpu_tag_in); end
    checks++; if (fpu_op_type !== 4'h7 || fpu_fmt !== 2'd1 || fpu_frm !== 3'd3 || fpu_dataa !== 32'h11111111 || fpu_datab !== 32'h22222222 || fpu_datac !== 32'h33333333) begin errors++; $display("FAIL single_passthru: got op=%h a=%h b=%h c=%h expected 7/11111111/22222222/33333333", fpu_op_type, fpu_dataa, fpu_datab, fpu_datac); end
    tick();
    req_valid = 1'b0;
    checks++; if (pending !== 4'd1) begin errors++; $display("FAIL single_pending1: got %0d expected 1", pending); end
    tick(); tick();
    rsp_start(3'd0, 32'h3F800000, 1'b1, 5'h01);
    #1;
    checks++; if (fpu_ready_out !== 1'b1 || rsp_valid !== 1'b0) begin errors++; $display("FAIL single_pre_rsp: got ready_out=%b rsp_valid=%b expected 1/0", fpu_ready_out, rsp_valid); end
    tick();
    rsp_stop();
    checks++; if (rsp_valid !== 1'b1 || rsp_meta !== 16'h00A5 || rsp_result !== 32'h3F800000 || rsp_fflags !== 5'h01) begin errors++; $display("FAIL single_rsp: got v=%b meta=%h res=%h fl=%h expected 1/00a5/3f800000/01", rsp_valid, rsp_meta, rsp_result, rsp_fflags); end
    checks++; if (fflags_acc !== 5'h01 || pending !== 4'd0) begin errors++; $display("FAIL single_acc_pending: got %h/%0d expected 01/0", fflags_acc, pending); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_fill();
    logic [15:0] exp_meta [8];
    for (int i = 0; i < 8; i++) begin
      exp_meta[i] = 16'h0020 + 16'(i);
      req_valid = 1'b1; req_meta = exp_meta[i];
      #1;
      checks++; if (fpu_tag_in !== 3'(i) || req_ready !== 1'b1) begin errors++; $display("FAIL fill_tag%0d: got tag=%0d ready=%b expected %0d/1", i, fpu_tag_in, req_ready, i); end
      tick();
    end
    req_meta = 16'h0033;
    #1;
    checks++; if (pending !== 4'd8 || req_ready !== 1'b0 || fpu_valid_in !== 1'b0) begin errors++; $display("FAIL fill_full: got pending=%0d ready=%b valid=%b expected 8/0/0", pending, req_ready, fpu_valid_in); end
    rsp_start(3'd3, 32'h0, 1'b0, 5'h0);
    #1;
    checks++; if (req_ready !== 1'b0 || fpu_valid_in !== 1'b0) begin errors++; $display("FAIL fill_same_cycle: got ready=%b valid=%b expected 0/0", req_ready, fpu_valid_in); end
    tick();
    rsp_stop();
    checks++; if (req_ready !== 1'b1 || fpu_tag_in !== 3'd3 || rsp_meta !== 16'h0023) begin errors++; $display("FAIL fill_reuse3: got ready=%b tag=%0d meta=%h expected 1/3/0023", req_ready, fpu_tag_in, rsp_meta); end
    tick();
    req_valid = 1'b0;
    exp_meta[3] = 16'h0033;
    checks++; if (pending !== 4'd8) begin errors++; $display("FAIL fill_refull: got %0d expected 8", pending); end
    for (int i = 0; i < 8; i++) begin
      rsp_start(3'(i), 32'h0, 1'b0, 5'h0);
      tick();
      checks++; if (rsp_valid !== 1'b1 || rsp_meta !== exp_meta[i]) begin errors++; $display("FAIL drain_meta%0d: got v=%b meta=%h expected 1/%h", i, rsp_valid, rsp_meta, exp_meta[i]); end
    end
    rsp_stop();
    tick();
    checks++; if (pending !== 4'd0 || rsp_valid !== 1'b0) begin errors++; $display("FAIL drain_done: got pending=%0d v=%b expected 0/0", pending, rsp_valid); end
  endtask

  task automatic test_out_of_order();
    issue(16'h0010); issue(16'h0011); issue(16'h0012);
    rsp_start(3'd2, 32'h2, 1'b0, 5'h0);
    tick();
    rsp_start(3'd0, 32'h0, 1'b0, 5'h0);
    checks++; if (rsp_meta !== 16'h0012 || rsp_result !== 32'h2) begin errors++; $display("FAIL ooo_first: got %h/%h expected 0012/2", rsp_meta, rsp_result); end
    tick();
    rsp_start(3'd1, 32'h1, 1'b0, 5'h0);
    checks++; if (rsp_meta !== 16'h0010) begin errors++; $display("FAIL ooo_second: got %h expected 0010", rsp_meta); end
    tick();
    rsp_stop();
    checks++; if (rsp_meta !== 16'h0011 || pending !== 4'd0) begin errors++; $display("FAIL ooo_third: got %h/%0d expected 0011/0", rsp_meta, pending); end
    tick();
  endtask

  task automatic test_back_to_back();
    issue(16'h0050);
    req_valid = 1'b1; req_meta = 16'h0051;
    rsp_start(3'd0, 32'h50, 1'b0, 5'h0);
    #1;
    checks++; if (fpu_tag_in !== 3'd1 || req_ready !== 1'b1) begin errors++; $display("FAIL b2b_tag: got %0d/%b expected 1/1", fpu_tag_in, req_ready); end
    tick();
    req_valid = 1'b0;
    rsp_start(3'd1, 32'h51, 1'b0, 5'h0);
    checks++; if (pending !== 4'd1 || rsp_meta !== 16'h0050) begin errors++; $display("FAIL b2b_pending: got %0d/%h expected 1/0050", pending, rsp_meta); end
    tick();
    rsp_stop();
    checks++; if (pending !== 4'd0 || rsp_meta !== 16'h0051) begin errors++; $display("FAIL b2b_second: got %0d/%h expected 0/0051", pending, rsp_meta); end
    tick();
  endtask

  task automatic test_backpressure();
    issue(16'h0040); issue(16'h0041);
    rsp_ready = 1'b0;
    rsp_start(3'd0, 32'h111, 1'b0, 5'h0);
    tick();
    rsp_start(3'd1, 32'h222, 1'b0, 5'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || fpu_ready_out !== 1'b0 || rsp_meta !== 16'h0040 || rsp_result !== 32'h111) begin errors++; $display("FAIL bp_hold%0d: got v=%b rdy=%b meta=%h res=%h expected 1/0/0040/111", i, rsp_valid, fpu_ready_out, rsp_meta, rsp_result); end
      tick();
    end
    rsp_ready = 1'b1;
    #1;
    checks++; if (fpu_ready_out !== 1'b1) begin errors++; $display("FAIL bp_release: got %b expected 1", fpu_ready_out); end
    tick();
    rsp_stop();
    checks++; if (rsp_valid !== 1'b1 || rsp_meta !== 16'h0041 || rsp_result !== 32'h222 || pending !== 4'd0) begin errors++; $display("FAIL bp_drain: got v=%b meta=%h res=%h pend=%0d expected 1/0041/222/0", rsp_valid, rsp_meta, rsp_result, pending); end
    tick();
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL bp_empty: got %b expected 0", rsp_valid); end
  endtask

  task automatic test_fflags();
    issue(16'h0060); issue(16'h0061); issue(16'h0062);
    rsp_start(3'd0, 32'h0, 1'b1, 5'h10);
    tick();
    rsp_stop();
    checks++; if (fflags_acc !== 5'h11) begin errors++; $display("FAIL ff_accum: got %h expected 11", fflags_acc); end
    rsp_start(3'd1, 32'h0, 1'b1, 5'h04);
    fflags_clr = 1'b1;
    tick();
    rsp_stop();
    fflags_clr = 1'b0;
    checks++; if (fflags_acc !== 5'h04 || rsp_fflags !== 5'h04) begin errors++; $display("FAIL ff_clr_same: got acc=%h rsp=%h expected 04/04", fflags_acc, rsp_fflags); end
    rsp_start(3'd2, 32'h0, 1'b0, 5'h1F);
    tick();
    rsp_stop();
    checks++; if (fflags_acc !== 5'h04 || rsp_fflags !== 5'h00) begin errors++; $display("FAIL ff_noflags: got acc=%h rsp=%h expected 04/00", fflags_acc, rsp_fflags); end
    tick();
  endtask

  task automatic test_error_reset();
    rsp_start(3'd5, 32'hDEAD, 1'b0, 5'h0);
    tick();
    rsp_stop();
    checks++; if (tag_err !== 1'b1 || pending !== 4'd0 || rsp_valid !== 1'b1) begin errors++; $display("FAIL err_free_tag: got err=%b pend=%0d v=%b expected 1/0/1", tag_err, pending, rsp_valid); end
    tick();
    issue(16'h0070); issue(16'h0071); issue(16'h0072); issue(16'h0073);
    checks++; if (pending !== 4'd4 || tag_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got pend=%0d err=%b expected 4/1", pending, tag_err); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (pending !== 4'd0 || rsp_valid !== 1'b0 || tag_err !== 1'b0) begin errors++; $display("FAIL async_reset: got pend=%0d v=%b err=%b expected 0/0/0", pending, rsp_valid, tag_err); end
    tick();
    reset_n = 1'b1;
    tick();
    rsp_start(3'd0, 32'h0, 1'b0, 5'h0);
    tick();
    rsp_stop();
    checks++; if (tag_err !== 1'b1 || pending !== 4'd0) begin errors++; $display("FAIL post_reset_rsp: got err=%b pend=%0d expected 1/0", tag_err, pending); end
    tick();
  endtask

  initial begin
    req_valid = 1'b0; req_meta = '0; req_op = '0; req_fmt = '0; req_frm = '0;
    req_dataa = '0; req_datab = '0; req_datac = '0;
    fpu_ready_in = 1'b1; fpu_valid_out = 1'b0; fpu_result = '0;
    fpu_has_fflags = 1'b0; fpu_fflags = '0; fpu_tag_out = '0;
    rsp_ready = 1'b1; fflags_clr = 1'b0;
    test_reset();
    test_single_op();
    test_fill();
    test_out_of_order();
    test_back_to_back();
    test_backpressure();
    test_fflags();
    test_error_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
